// File: rtl/pkt_store_fwd_buffer.sv
// pkt_store_fwd_buffer: store-and-forward packet buffer with cut-through fallback (in_* upstream bus, out_* registered downstream bus, stored_pkts/buf_words occupancy)
module pkt_store_fwd_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int CTRL_WIDTH = DATA_WIDTH / 8,
  parameter int ADDR_WIDTH = 9,
  parameter int RDY_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic                  in_wr,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic                  out_wr,
  input  logic                  out_rdy,
  output logic [ADDR_WIDTH:0]   stored_pkts,
  output logic [ADDR_WIDTH:0]   buf_words
);
  localparam int W = DATA_WIDTH + CTRL_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
  localparam logic [ADDR_WIDTH:0] MARGIN = (ADDR_WIDTH + 1)'(RDY_MARGIN);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SEND = 2'd1;
  localparam logic [1:0] CUT  = 2'd2;
  logic [W-1:0] mem [0:(1<<ADDR_WIDTH)-1];
  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [1:0] state, state_nxt;
  logic [W-1:0] rd_word;
  logic in_prev_ctrl_is_0, out_prev_ctrl_is_0, cut_pkt_done;
  logic reading, wr_en, rd_en, wr_eop, rd_eop, cut_sup, pkt_inc, pkt_dec;
  assign rd_word   = mem[rd_ptr];
  assign reading   = state == SEND || state == CUT;
  assign wr_en     = in_wr && buf_words != DEPTH;
  assign rd_en     = reading && out_rdy && buf_words != '0;
  assign wr_eop    = wr_en && in_ctrl != '0 && in_prev_ctrl_is_0;
  assign rd_eop    = rd_en && rd_word[W-1 -: CTRL_WIDTH] != '0 && out_prev_ctrl_is_0;
  assign state_nxt = reading ? (rd_eop ? IDLE : state) :
                     stored_pkts != '0 ? SEND :
                     buf_words >= DEPTH - MARGIN ? CUT : IDLE;
  assign cut_sup   = wr_eop && state_nxt == CUT && !cut_pkt_done;
  assign pkt_inc   = wr_eop && !cut_sup;
  assign pkt_dec   = rd_eop && state == SEND;
  assign in_rdy    = DEPTH - buf_words > MARGIN;
  always_ff @(posedge clk) if (wr_en) mem[wr_ptr] <= {in_ctrl, in_data};
  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= IDLE;
      wr_ptr             <= '0;
      rd_ptr             <= '0;
      buf_words          <= '0;
      stored_pkts        <= '0;
      in_prev_ctrl_is_0  <= 1'b0;
      out_prev_ctrl_is_0 <= 1'b0;
      cut_pkt_done       <= 1'b0;
      out_wr             <= 1'b0;
      out_data           <= '0;
      out_ctrl           <= '0;
    end else begin
      state        <= state_nxt;
      cut_pkt_done <= state_nxt == CUT ? (cut_pkt_done | cut_sup) : 1'b0;
      buf_words    <= buf_words + (ADDR_WIDTH + 1)'(wr_en) - (ADDR_WIDTH + 1)'(rd_en);
      stored_pkts  <= stored_pkts + (ADDR_WIDTH + 1)'(pkt_inc) - (ADDR_WIDTH + 1)'(pkt_dec);
      out_wr       <= rd_en;
      if (wr_en) begin
        wr_ptr            <= wr_ptr + 1'b1;
        in_prev_ctrl_is_0 <= in_ctrl == '0;
      end
      if (rd_en) begin
        rd_ptr               <= rd_ptr + 1'b1;
        out_prev_ctrl_is_0   <= rd_word[W-1 -: CTRL_WIDTH] == '0;
        {out_ctrl, out_data} <= rd_word;
      end
    end
  end
endmodule

// File: doc/pkt_store_fwd_buffer.md
Name: pkt_store_fwd_buffer

Overview:
- Store-and-forward packet buffer placed directly downstream of the rate limiter, in front of the output queue interface.
- Absorbs the rate limiter's word-at-a-time output and releases only complete packets, so downstream sees gap-free packet bursts.
- Falls back to cut-through when a single packet exceeds the buffer capacity, so an oversized packet cannot deadlock the pipeline.
- Uses the standard NetFPGA data/ctrl/wr/rdy module-header packet bus on both sides.

Parameters:
- DATA_WIDTH, 64, data bus width.
- CTRL_WIDTH, DATA_WIDTH/8, ctrl bus width.
- ADDR_WIDTH, 9, log2 of buffer depth in words (default 512 words).
- RDY_MARGIN, 4, free-word headroom below which in_rdy deasserts.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- in_data  in  DATA_WIDTH  upstream word.
- in_ctrl  in  CTRL_WIDTH  upstream ctrl.
- in_wr  in  1  upstream write strobe.
- in_rdy  out  1  buffer can accept a word.
- out_data  out  DATA_WIDTH  downstream word (registered).
- out_ctrl  out  CTRL_WIDTH  downstream ctrl (registered).
- out_wr  out  1  downstream write strobe (registered).
- out_rdy  in  1  downstream can accept a word.
- stored_pkts  out  ADDR_WIDTH+1  complete packets currently buffered.
- buf_words  out  ADDR_WIDTH+1  words currently buffered.

Behaviour:
- Reset: out_wr=0, out_data=0, out_ctrl=0, stored_pkts=0, buf_words=0, state=IDLE; read/write pointers cleared; both prev-ctrl-zero flags cleared. After reset, in_rdy=1.
- Buffer: circular RAM of 2^ADDR_WIDTH words, each word {ctrl,data}. Pointers wrap modulo depth.
- Write side:
  - A word is written on every cycle with in_wr=1; upstream honours in_rdy.
  - in_rdy = (depth - buf_words) > RDY_MARGIN.
  - A write while the buffer is full is an upstream violation: the word is discarded and counters are unchanged.
- EOP detection, write side: in_ctrl != 0 while in_prev_ctrl_is_0 = 1. in_prev_ctrl_is_0 updates on every write.
- EOP detection, read side: same rule applied to the word being read, using out_prev_ctrl_is_0, which updates on every read.
- stored_pkts:
  - +1 on a write-side EOP.
  - -1 when an EOP word is read, only if that packet was stored-complete (not in CUT).
  - Simultaneous increment and decrement leaves it unchanged.
- buf_words: +1 per write, -1 per read; simultaneous write and read leaves it unchanged.
- FSM:
  - IDLE:
    - If stored_pkts > 0, go to SEND.
    - Else if buf_words >= depth - RDY_MARGIN, go to CUT (oversized packet).
    - No reads in IDLE.
  - SEND: rd_en = out_rdy and buffer not empty. On reading the EOP word, go to IDLE.
  - CUT:
    - rd_en = out_rdy and buffer not empty; output may starve mid-packet, which is permitted in CUT.
    - On reading the EOP word, go to IDLE and do not decrement stored_pkts.
    - If that packet's write-side EOP arrived while in CUT, it is not counted in stored_pkts either. Track this with a cut_pkt_done flag that suppresses the one increment.
- Output timing: out_wr is registered rd_en, so a word appears 1 cycle after rd_en. out_data/out_ctrl come from the registered RAM read and are valid when out_wr=1.
- Packets leave in arrival order; no reordering or dropping.
- Reset mid-packet: all contents are lost. The first post-reset word is treated as a header, since prev-ctrl-zero flags are cleared.

Test Plan:
- Single 10-word packet (1 header word ctrl=0xFF, 8 payload ctrl=0, last ctrl=0x01), out_rdy=1 → no out_wr until the EOP is written. Output starts 2 cycles after the EOP write (1 cycle FSM, 1 cycle read), then 10 consecutive out_wr with identical data/ctrl. stored_pkts goes 0→1→0.
- Three back-to-back 4-word packets, out_rdy held 0 → buf_words=12, stored_pkts=3. Raise out_rdy → 12 contiguous output words in order; stored_pkts reaches 0.
- Toggle out_rdy every cycle during SEND → no word lost or duplicated. out_wr never asserts on a word issued while out_rdy=0.
- 600-word packet with ADDR_WIDTH=9, RDY_MARGIN=4, out_rdy=0 until in_rdy falls → in_rdy drops at buf_words=508. Raising out_rdy puts the FSM in CUT; all 600 words exit intact; stored_pkts stays 0 throughout.
- Simultaneous write-side EOP and read-side EOP on the same cycle → stored_pkts unchanged; buf_words unchanged on a concurrent write and read.
- Assert reset for 1 cycle mid-packet (buf_words=5) → next cycle out_wr=0, buf_words=0, stored_pkts=0, in_rdy=1. A following clean packet passes unchanged.
